// File: rtl/pattern_loader_pkg.sv
// Shared array geometry, PE cell-state encodings and ASCII command bytes for the pattern loader.
package pattern_loader_pkg;

    localparam int unsigned N_PX_BITS     = 2;
    localparam int unsigned N_PY_BITS     = 2;
    localparam int unsigned PE_STATE_BITS = 1;

    localparam logic [PE_STATE_BITS-1:0] PE_STATE_LIVE = 1'b1;
    localparam logic [PE_STATE_BITS-1:0] PE_STATE_DEAD = 1'b0;

    localparam logic [7:0] CH_START    = 8'h53;  // 'S'
    localparam logic [7:0] CH_END      = 8'h45;  // 'E'
    localparam logic [7:0] CH_LIVE     = 8'h4F;  // 'O'
    localparam logic [7:0] CH_LIVE_ALT = 8'h2A;  // '*'
    localparam logic [7:0] CH_DEAD     = 8'h2E;  // '.'
    localparam logic [7:0] CH_NL       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;

    typedef enum logic [2:0] {
        BC_LIVE,
        BC_DEAD,
        BC_NL,
        BC_CR,
        BC_END,
        BC_START,
        BC_OTHER
    } byte_class_e;

    typedef struct packed {
        logic [N_PX_BITS-1:0]     x;
        logic [N_PY_BITS-1:0]     y;
        logic [PE_STATE_BITS-1:0] state;
    } cell_wr_t;

    function automatic byte_class_e classify(input logic [7:0] b);
        byte_class_e c;
        c = BC_OTHER;
        if (b == CH_LIVE || b == CH_LIVE_ALT) c = BC_LIVE;
        else if (b == CH_DEAD)                c = BC_DEAD;
        else if (b == CH_NL)                  c = BC_NL;
        else if (b == CH_CR)                  c = BC_CR;
        else if (b == CH_END)                 c = BC_END;
        else if (b == CH_START)               c = BC_START;
        return c;
    endfunction

endpackage

// File: rtl/pattern_loader.sv
// Loads an ASCII cell pattern into the PE array: clears the array on 'S', then writes
// one cell per accepted character while holding array evolution off.
module pattern_loader
    import pattern_loader_pkg::*;
#(
    parameter int unsigned NX = 2**N_PX_BITS,
    parameter int unsigned NY = 2**N_PY_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [N_PX_BITS-1:0]     wr_x,
    output logic [N_PY_BITS-1:0]     wr_y,
    output logic [PE_STATE_BITS-1:0] wr_state,
    output logic                     run_en,
    output logic                     busy,
    output logic                     bad_char
);

    localparam int unsigned XW = N_PX_BITS + 1;
    localparam logic [XW-1:0]        X_END  = XW'(NX);
    localparam logic [N_PX_BITS-1:0] X_LAST = N_PX_BITS'(NX - 1);
    localparam logic [N_PY_BITS-1:0] Y_LAST = N_PY_BITS'(NY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD
    } state_e;

    state_e                 state;
    logic [N_PX_BITS-1:0]   cx;
    logic [N_PY_BITS-1:0]   cy;
    logic [N_PX_BITS-1:0]   cx_nxt;
    logic [N_PY_BITS-1:0]   cy_nxt;
    logic [XW-1:0]          cur_x;
    logic [N_PY_BITS-1:0]   cur_y;
    cell_wr_t               wr_q;
    logic                   accept;
    logic                   start;
    byte_class_e            cls;

    // Handshake and run gating are pure decodes of the state register.
    assign in_ready = (state != ST_CLEAR);
    assign run_en   = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    assign accept = in_valid && in_ready;
    assign cls    = classify(in_data);
    assign start  = accept && (cls == BC_START);

    assign wr_x     = wr_q.x;
    assign wr_y     = wr_q.y;
    assign wr_state = wr_q.state;

    // Row-major successor of the cell currently being cleared.
    always_comb begin
        cx_nxt = cx + N_PX_BITS'(1);
        cy_nxt = cy;
        if (cx == X_LAST) begin
            cx_nxt = '0;
            cy_nxt = cy + N_PY_BITS'(1);
        end
    end

    // cx/cy always name the cell on the write port during CLEAR, so the final
    // write is recognised by the counters alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cx       <= '0;
            cy       <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            wr_en    <= 1'b0;
            wr_q     <= '{x: '0, y: '0, state: PE_STATE_DEAD};
            bad_char <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                state    <= ST_CLEAR;
                cx       <= '0;
                cy       <= '0;
                bad_char <= 1'b0;
                wr_en    <= 1'b1;
                wr_q     <= '{x: '0, y: '0, state: PE_STATE_DEAD};
            end else begin
                unique case (state)
                    ST_IDLE: begin
                    end
                    ST_CLEAR: begin
                        if (cx == X_LAST && cy == Y_LAST) begin
                            state <= ST_LOAD;
                            cur_x <= '0;
                            cur_y <= '0;
                        end else begin
                            cx    <= cx_nxt;
                            cy    <= cy_nxt;
                            wr_en <= 1'b1;
                            wr_q  <= '{x: cx_nxt, y: cy_nxt, state: PE_STATE_DEAD};
                        end
                    end
                    ST_LOAD: begin
                        if (accept) begin
                            unique case (cls)
                                BC_LIVE, BC_DEAD: begin
                                    // Cursor saturates at X_END; excess characters are swallowed.
                                    if (cur_x < X_END) begin
                                        wr_en <= 1'b1;
                                        wr_q  <= '{x: cur_x[N_PX_BITS-1:0], y: cur_y,
                                                   state: (cls == BC_LIVE) ? PE_STATE_LIVE
                                                                           : PE_STATE_DEAD};
                                        cur_x <= cur_x + XW'(1);
                                    end
                                end
                                BC_NL: begin
                                    cur_x <= '0;
                                    if (cur_y == Y_LAST) state <= ST_IDLE;
                                    else                 cur_y <= cur_y + N_PY_BITS'(1);
                                end
                                BC_END:  state <= ST_IDLE;
                                BC_CR: begin
                                end
                                BC_OTHER: bad_char <= 1'b1;
                                default: begin
                                end
                            endcase
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
